// File: rtl/score_keeper_if.sv
// Bundle between the score keeper and its neighbours: goal/tick/start inputs
// plus the registered score, timer and serve outputs.
interface score_keeper_if;
  logic       clk_1ms;
  logic       start;
  logic       p1_goal;
  logic       p2_goal;
  logic [1:0] game_state;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [5:0] match_sec;
  logic       ball_hold;
  logic       serve;
  logic       serve_dir;
  logic       time_up;

  modport master (
    output clk_1ms, start, p1_goal, p2_goal, game_state,
    input  p1_score, p2_score, match_sec, ball_hold, serve, serve_dir, time_up
  );

  modport slave (
    input  clk_1ms, start, p1_goal, p2_goal, game_state,
    output p1_score, p2_score, match_sec, ball_hold, serve, serve_dir, time_up
  );
endinterface

// File: rtl/score_keeper.sv
// Rally sequencer and match clock: counts goals, holds and serves the ball,
// and stops play on a win, a decoder-reported win or the match clock running out.
module score_keeper #(
  parameter int WIN_SCORE      = 5,
  parameter int SERVE_DELAY_MS = 1000,
  parameter int MS_PER_SEC     = 1000,
  parameter int MATCH_SECONDS  = 60
) (
  input  logic         clk_i,
  input  logic         reset_i,
  score_keeper_if.slave bus
);

  localparam int HW = $clog2(SERVE_DELAY_MS + 1);
  localparam int MW = (MS_PER_SEC > 1) ? $clog2(MS_PER_SEC) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(SERVE_DELAY_MS - 1);
  localparam logic [MW-1:0] MS_LAST   = MW'(MS_PER_SEC - 1);
  localparam logic [5:0]    SEC_LAST  = 6'(MATCH_SECONDS - 1);
  localparam logic [3:0]    WIN       = 4'(WIN_SCORE);

  typedef enum logic [1:0] {IDLE, HOLD, PLAY, OVER} state_e;

  state_e        stateQ, stateD;
  logic          clk1msQ;
  logic [HW-1:0] holdCntQ, holdCntD;
  logic [MW-1:0] msCntQ, msCntD;
  logic [3:0]    p1Q, p1D, p2Q, p2D;
  logic [5:0]    secQ, secD;
  logic          ballHoldQ, ballHoldD;
  logic          serveQ, serveD;
  logic          dirQ, dirD;
  logic          timeUpQ, timeUpD;
  logic          msTick;
  logic          goOver;

  assign msTick = bus.clk_1ms & ~clk1msQ;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stateQ    <= IDLE;
      clk1msQ   <= 1'b0;
      holdCntQ  <= '0;
      msCntQ    <= '0;
      p1Q       <= '0;
      p2Q       <= '0;
      secQ      <= '0;
      ballHoldQ <= 1'b1;
      serveQ    <= 1'b0;
      dirQ      <= 1'b0;
      timeUpQ   <= 1'b0;
    end else begin
      stateQ    <= stateD;
      clk1msQ   <= bus.clk_1ms;
      holdCntQ  <= holdCntD;
      msCntQ    <= msCntD;
      p1Q       <= p1D;
      p2Q       <= p2D;
      secQ      <= secD;
      ballHoldQ <= ballHoldD;
      serveQ    <= serveD;
      dirQ      <= dirD;
      timeUpQ   <= timeUpD;
    end
  end

  always_comb begin
    stateD    = stateQ;
    holdCntD  = holdCntQ;
    msCntD    = msCntQ;
    p1D       = p1Q;
    p2D       = p2Q;
    secD      = secQ;
    ballHoldD = ballHoldQ;
    serveD    = 1'b0;
    dirD      = dirQ;
    timeUpD   = timeUpQ;
    goOver    = 1'b0;

    case (stateQ)
      IDLE, OVER: begin
        ballHoldD = 1'b1;
        if (stateQ == IDLE) begin
          holdCntD = '0;
          msCntD   = '0;
        end
        if (bus.start) begin
          stateD   = HOLD;
          holdCntD = '0;
          msCntD   = '0;
          p1D      = '0;
          p2D      = '0;
          secD     = '0;
          timeUpD  = 1'b0;
          dirD     = 1'b0;
        end
      end
      HOLD: begin
        ballHoldD = 1'b1;
        if (msTick) begin
          if (holdCntQ == HOLD_LAST) begin
            serveD    = 1'b1;
            ballHoldD = 1'b0;
            stateD    = PLAY;
            holdCntD  = '0;
          end else begin
            holdCntD = holdCntQ + HW'(1);
          end
        end
      end
      PLAY: begin
        ballHoldD = 1'b0;
        if (bus.p1_goal && p1Q != WIN) p1D = p1Q + 4'd1;
        if (bus.p2_goal && p2Q != WIN) p2D = p2Q + 4'd1;
        // Next serve goes toward whoever just conceded; a double goal keeps direction.
        if (bus.p1_goal && !bus.p2_goal) dirD = 1'b1;
        if (bus.p2_goal && !bus.p1_goal) dirD = 1'b0;
        if (bus.p1_goal || bus.p2_goal) begin
          if (p1D == WIN || p2D == WIN) begin
            goOver = 1'b1;
          end else begin
            stateD    = HOLD;
            ballHoldD = 1'b1;
            holdCntD  = '0;
          end
        end
      end
      default: ;
    endcase

    if (stateQ == HOLD || stateQ == PLAY) begin
      if (msTick) begin
        if (msCntQ == MS_LAST) begin
          msCntD = '0;
          secD   = secQ + 6'd1;
          if (secQ == SEC_LAST) begin
            timeUpD = 1'b1;
            goOver  = 1'b1;
          end
        end else begin
          msCntD = msCntQ + MW'(1);
        end
      end
      if (bus.game_state[1]) goOver = 1'b1;
    end

    // Ending the match overrides any serve or return to HOLD chosen above.
    if (goOver) begin
      stateD    = OVER;
      serveD    = 1'b0;
      ballHoldD = 1'b1;
    end
  end

  assign bus.p1_score  = p1Q;
  assign bus.p2_score  = p2Q;
  assign bus.match_sec = secQ;
  assign bus.ball_hold = ballHoldQ;
  assign bus.serve     = serveQ;
  assign bus.serve_dir = dirQ;
  assign bus.time_up   = timeUpQ;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: directed rally scenarios plus random play, all checked
// against an event-level model of the match rules.
module tb_score_keeper;

  localparam int WIN  = 5;
  localparam int SD   = 3;
  localparam int MPS  = 4;
  localparam int MSEC = 5;
  localparam logic [17:0] RESET_VEC = 18'h00008;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;

  // Match model: 0=idle 1=hold 2=play 3=over
  int mState, mP1, mP2, mSec, mMs, mHold, mDir, mTimeUp, mServe, mPrevClk;

  always #5 clk = ~clk;

  score_keeper_if bus();

  score_keeper #(
    .WIN_SCORE(WIN), .SERVE_DELAY_MS(SD), .MS_PER_SEC(MPS), .MATCH_SECONDS(MSEC)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .bus    (bus)
  );

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired got=running exp=finished");
    $fatal(1, "[TB] watchdog");
  end

  function automatic void model_reset();
    mState = 0; mP1 = 0; mP2 = 0; mSec = 0; mMs = 0; mHold = 0;
    mDir = 0; mTimeUp = 0; mServe = 0; mPrevClk = 0;
  endfunction

  // One clock edge of the match rules, expressed in goals, ms ticks and seconds.
  function automatic void model_edge(input bit lvl, input bit g1, input bit g2,
                                     input bit st, input bit won);
    bit tick;
    bit over;
    bit active;
    tick = lvl && (mPrevClk == 0);
    over = 1'b0;
    active = (mState == 1 || mState == 2);
    mPrevClk = lvl;
    mServe = 0;
    if (mState == 0 || mState == 3) begin
      if (st) begin
        mState = 1; mP1 = 0; mP2 = 0; mSec = 0; mMs = 0; mHold = 0;
        mTimeUp = 0; mDir = 0;
      end
    end else if (mState == 1) begin
      if (tick) begin
        mHold++;
        if (mHold == SD) begin
          mState = 2;
          mServe = 1;
        end
      end
    end else begin
      if (g1 && mP1 < WIN) mP1++;
      if (g2 && mP2 < WIN) mP2++;
      if (g1 && !g2) mDir = 1;
      if (g2 && !g1) mDir = 0;
      if (g1 || g2) begin
        if (mP1 == WIN || mP2 == WIN) over = 1'b1;
        else begin
          mState = 1;
          mHold = 0;
        end
      end
    end
    if (active) begin
      if (tick) begin
        mMs++;
        if (mMs == MPS) begin
          mMs = 0;
          mSec++;
          if (mSec == MSEC) begin
            mTimeUp = 1;
            over = 1'b1;
          end
        end
      end
      if (won) over = 1'b1;
    end
    if (over) begin
      mState = 3;
      mServe = 0;
    end
  endfunction

  function automatic logic [17:0] exp_vec();
    logic hold;
    hold = (mState != 2);
    return {4'(mP1), 4'(mP2), 6'(mSec), hold, 1'(mServe), 1'(mDir), 1'(mTimeUp)};
  endfunction

  function automatic logic [17:0] dut_vec();
    return {bus.p1_score, bus.p2_score, bus.match_sec, bus.ball_hold,
            bus.serve, bus.serve_dir, bus.time_up};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_edge(input bit lvl, input bit g1, input bit g2, input bit st);
    bus.clk_1ms = lvl;
    bus.p1_goal = g1;
    bus.p2_goal = g2;
    bus.start   = st;
    step();
    model_edge(lvl, g1, g2, st, bus.game_state[1]);
    bus.p1_goal = 1'b0;
    bus.p2_goal = 1'b0;
    bus.start   = 1'b0;
  endtask

  task automatic tick();
    drive_edge(1'b1, 1'b0, 1'b0, 1'b0);
    drive_edge(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.clk_1ms = 1'b0;
    bus.p1_goal = 1'b0;
    bus.p2_goal = 1'b0;
    bus.start = 1'b0;
    bus.game_state = 2'b00;
    step();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (dut_vec() !== RESET_VEC) begin
      bad++;
      $display("[TB] FAIL reset_values got=%h exp=%h", dut_vec(), RESET_VEC);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("[TB] FAIL idle_tick%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_serve();
    do_reset();
    drive_edge(1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (bus.ball_hold !== 1'b1 || bus.serve !== 1'b0) begin
      bad++;
      $display("[TB] FAIL start_hold got=%b%b exp=10", bus.ball_hold, bus.serve);
    end
    for (int i = 1; i <= SD; i++) begin
      drive_edge(1'b1, 1'b0, 1'b0, 1'b0);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("[TB] FAIL serve_tick%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
      drive_edge(1'b0, 1'b0, 1'b0, 1'b0);
    end
    total++;
    if (bus.serve !== 1'b0 || bus.ball_hold !== 1'b0 || bus.serve_dir !== 1'b0) begin
      bad++;
      $display("[TB] FAIL serve_one_cycle got=%b%b%b exp=000",
               bus.serve, bus.ball_hold, bus.serve_dir);
    end
  endtask

  task automatic test_goal();
    drive_edge(1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (bus.p1_score !== 4'd1 || bus.serve_dir !== 1'b1 || bus.ball_hold !== 1'b1) begin
      bad++;
      $display("[TB] FAIL p1_goal got=%0d/%b/%b exp=1/1/1",
               bus.p1_score, bus.serve_dir, bus.ball_hold);
    end
    drive_edge(1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if (bus.p2_score !== 4'd0) begin
      bad++;
      $display("[TB] FAIL goal_in_hold got=%0d exp=0", bus.p2_score);
    end
    for (int i = 1; i <= SD; i++) begin
      drive_edge(1'b1, 1'b0, 1'b0, 1'b0);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("[TB] FAIL reserve_tick%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
      drive_edge(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_simultaneous();
    bit seq1 [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      drive_edge(1'b0, seq1[k], !seq1[k], 1'b0);
      repeat (SD) tick();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("[TB] FAIL rally%0d got=%h exp=%h", k, dut_vec(), exp_vec());
      end
    end
    drive_edge(1'b0, 1'b1, 1'b1, 1'b0);
    total++;
    if (bus.p1_score !== 4'd3 || bus.p2_score !== 4'd4 || bus.serve_dir !== 1'b1 ||
        bus.ball_hold !== 1'b1 || bus.time_up !== 1'b0) begin
      bad++;
      $display("[TB] FAIL both_goals got=%0d/%0d dir=%b hold=%b exp=3/4 dir=1 hold=1",
               bus.p1_score, bus.p2_score, bus.serve_dir, bus.ball_hold);
    end
  endtask

  task automatic test_win();
    do_reset();
    drive_edge(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (SD) tick();
    for (int k = 1; k <= WIN; k++) begin
      drive_edge(1'b0, 1'b1, 1'b0, 1'b0);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("[TB] FAIL win_goal%0d got=%h exp=%h", k, dut_vec(), exp_vec());
      end
      if (k < WIN) repeat (SD) tick();
    end
    total++;
    if (bus.p1_score !== 4'd5 || bus.ball_hold !== 1'b1) begin
      bad++;
      $display("[TB] FAIL win_over got=%0d hold=%b exp=5 hold=1", bus.p1_score, bus.ball_hold);
    end
    drive_edge(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (5) tick();
    total++;
    if (bus.p1_score !== 4'd5 || bus.p2_score !== 4'd0 || dut_vec() !== exp_vec()) begin
      bad++;
      $display("[TB] FAIL over_frozen got=%h exp=%h", dut_vec(), exp_vec());
    end
    drive_edge(1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (dut_vec() !== RESET_VEC) begin
      bad++;
      $display("[TB] FAIL restart_clear got=%h exp=%h", dut_vec(), RESET_VEC);
    end
  endtask

  task automatic test_timeup();
    do_reset();
    drive_edge(1'b0, 1'b0, 1'b0, 1'b1);
    for (int t = 1; t <= MPS * MSEC; t++) begin
      tick();
      if (t % MPS == 0) begin
        total++;
        if (bus.match_sec !== 6'(t / MPS) || dut_vec() !== exp_vec()) begin
          bad++;
          $display("[TB] FAIL sec_at_tick%0d got=%h exp=%h", t, dut_vec(), exp_vec());
        end
      end
    end
    total++;
    if (bus.time_up !== 1'b1 || bus.ball_hold !== 1'b1) begin
      bad++;
      $display("[TB] FAIL time_up got=%b hold=%b exp=1 hold=1", bus.time_up, bus.ball_hold);
    end
    repeat (6) tick();
    total++;
    if (bus.match_sec !== 6'd5 || bus.time_up !== 1'b1) begin
      bad++;
      $display("[TB] FAIL sec_frozen got=%0d exp=5", bus.match_sec);
    end
  endtask

  task automatic test_goal_at_timeup();
    do_reset();
    drive_edge(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (MPS * MSEC - 1) tick();
    drive_edge(1'b1, 1'b1, 1'b0, 1'b0);
    total++;
    if (bus.p1_score !== 4'd1 || bus.time_up !== 1'b1 || bus.ball_hold !== 1'b1 ||
        dut_vec() !== exp_vec()) begin
      bad++;
      $display("[TB] FAIL goal_at_timeup got=%h exp=%h", dut_vec(), exp_vec());
    end
    drive_edge(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    drive_edge(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    do_reset();
    total++;
    if (dut_vec() !== RESET_VEC) begin
      bad++;
      $display("[TB] FAIL reset_mid_hold got=%h exp=%h", dut_vec(), RESET_VEC);
    end
    drive_edge(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= SD; i++) begin
      drive_edge(1'b1, 1'b0, 1'b0, 1'b0);
      total++;
      if (bus.serve !== 1'(i == SD)) begin
        bad++;
        $display("[TB] FAIL hold_after_reset%0d got=%b exp=%b", i, bus.serve, i == SD);
      end
      drive_edge(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_game_state();
    do_reset();
    drive_edge(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (SD) tick();
    bus.game_state = 2'b01;
    drive_edge(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (bus.ball_hold !== 1'b0) begin
      bad++;
      $display("[TB] FAIL gs_not_won got=%b exp=0", bus.ball_hold);
    end
    bus.game_state = 2'b11;
    drive_edge(1'b0, 1'b0, 1'b0, 1'b0);
    bus.game_state = 2'b00;
    drive_edge(1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (bus.ball_hold !== 1'b1 || bus.p1_score !== 4'd0 || dut_vec() !== exp_vec()) begin
      bad++;
      $display("[TB] FAIL gs_won_over got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    int r;
    bit won;
    do_reset();
    won = 1'b0;
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(99, 0);
      if (r < 1) begin
        do_reset();
        won = 1'b0;
      end else begin
        if ($urandom_range(99, 0) < 3) won = !won;
        bus.game_state = {won, 1'($urandom_range(1, 0))};
        drive_edge(1'($urandom_range(1, 0)), $urandom_range(99, 0) < 12,
                   $urandom_range(99, 0) < 12, $urandom_range(99, 0) < 5);
      end
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("[TB] FAIL random%0d got=%h exp=%h", n, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    bus.clk_1ms = 1'b0;
    bus.start = 1'b0;
    bus.p1_goal = 1'b0;
    bus.p2_goal = 1'b0;
    bus.game_state = 2'b00;
    model_reset();
    test_reset();
    test_serve();
    test_goal();
    test_simultaneous();
    test_win();
    test_timeup();
    test_goal_at_timeup();
    test_reset_mid_hold();
    test_game_state();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Upstream stage of the game-state decoder. Converts ball-logic goal pulses into registered p1_score/p2_score, and runs the match-seconds timer from the 1 ms tick.
- Sequences each rally: freeze ball, serve hold-off, serve pulse, play, and stops scoring once the match is over.
- Outputs feed the game-state decoder and the ball/paddle logic.

Parameters:
WIN_SCORE, 5, goals that end the match; scores saturate here (must be ≤15)
SERVE_DELAY_MS, 1000, ms ticks the ball is held before each serve (≥1)
MS_PER_SEC, 1000, ms ticks per match second
MATCH_SECONDS, 60, match length in seconds (≤63)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high; clears all state
clk_1ms  in  1  1 kHz square wave from divider, synchronous to clk; rising edge detected internally
start  in  1  level; begins a match from IDLE or OVER
p1_goal  in  1  one-cycle pulse: player 1 scored
p2_goal  in  1  one-cycle pulse: player 2 scored
game_state  in  2  from decoder; 2'b10/2'b11 = match won
p1_score  out  4  player 1 goals
p2_score  out  4  player 2 goals
match_sec  out  6  elapsed match seconds
ball_hold  out  1  1 = ball frozen at centre
serve  out  1  one-cycle pulse launching the ball
serve_dir  out  1  0 = toward player 1, 1 = toward player 2
time_up  out  1  sticky; match clock expired

Behaviour:
- Reset (sync, high): state=IDLE; scores=0, match_sec=0, ms/hold counters=0, ball_hold=1, serve=0, serve_dir=0, time_up=0, clk_1ms edge register=0. Applies mid-rally and mid-hold with no residue.
- Tick: ms_tick = clk_1ms & ~clk_1ms_q. It is high one clk cycle, the cycle after the sampled rising edge.
- States: IDLE, HOLD, PLAY, OVER. All outputs are registered.

IDLE:
- ball_hold=1; counters held at 0.
- start=1 → HOLD. Scores, match_sec, time_up and serve_dir clear on that edge.

HOLD:
- ball_hold=1.
- Hold counter clears on entry and increments on each ms_tick.
- The ms_tick that brings the count to SERVE_DELAY_MS triggers the next edge: serve=1 for exactly one cycle, ball_hold=0, state=PLAY.

PLAY:
- p1_goal increments p1_score and sets serve_dir=1 (serve toward the conceding player).
- p2_goal increments p2_score and sets serve_dir=0.
- Both goals in the same cycle: both scores increment; serve_dir is unchanged.
- After a goal:
  - If either score now equals WIN_SCORE → OVER.
  - Otherwise → HOLD, with ball_hold=1 on the same edge.
- Scores saturate at WIN_SCORE.

Match timer:
- Advances in HOLD and PLAY only.
- ms counter counts 0..MS_PER_SEC-1; on wrap, match_sec increments.
- When match_sec reaches MATCH_SECONDS: time_up=1 and state → OVER on the same edge; match_sec holds.

OVER:
- Entered from HOLD/PLAY when game_state is 2'b10 or 2'b11, on time-up, or on a winning goal.
- ball_hold=1; scores, match_sec and time_up frozen.
- start=1 → HOLD, with a full clear as from IDLE.

Ignored inputs and simultaneous events:
- Goals outside PLAY are ignored.
- A goal in the same cycle as time-up is counted, then the block enters OVER.
- start while in HOLD or PLAY is ignored.

Test Plan (sim params SERVE_DELAY_MS=3, MS_PER_SEC=4, MATCH_SECONDS=5):
1. Reset; start=1 → HOLD, ball_hold=1. After 3 ms_ticks: one-cycle serve, serve_dir=0, ball_hold=0, state PLAY.
2. In PLAY, p1_goal pulse → p1_score=1, serve_dir=1, ball_hold=1 next cycle. Serve again after 3 ticks. p2_goal during HOLD → p2_score stays 0.
3. p1_goal and p2_goal in the same cycle with scores 2/3 → 3/4, serve_dir unchanged, state HOLD.
4. Drive p1 to 5 goals → p1_score=5, state OVER, ball_hold=1. Further goals leave 5/x. start → scores 0/0, match_sec=0, HOLD.
5. No goals for 20 ms_ticks → match_sec steps 1..5, time_up=1 at second 5, state OVER. match_sec stays 5 on extra ticks.
6. Assert reset mid-HOLD with hold count=2 → all outputs at reset values the next cycle. After start, a full 3-tick hold is required before serve.
